nibble_serial_subtractor: RTL and testbench

Multi-cycle unsigned subtractor with a borrow ripple. It computes diff = a - b - bin one 4-bit digit per clock, least-significant digit first. The block is the subtraction counterpart of the team's 4-bit-block ripple-carry adder datapath. It sits behind a start/done handshake so a controller can issue back-to-back subtractions without a full-width combinational borrow chain.

---
 rtl/nibble_serial_subtractor.sv | 129 ++++++++++++
 tb/tb_nibble_serial_subtractor.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor
//   Multi-cycle unsigned subtractor: diff = a - b - bin, one 4-bit digit per
//   clock, least-significant digit first, with the borrow rippled through a
//   register between digits. A start/done handshake lets a controller issue
//   back-to-back operations (start may be asserted in the done cycle).
//
// Parameters:
//   WIDTH   operand/result width in bits (multiple of 4, >= 4)
//
// Ports:
//   clk     clock, rising edge
//   rst_n   synchronous active-low reset
//   start   request a new operation (ignored while busy)
//   a, b    minuend / subtrahend, captured on the accepting edge
//   bin     borrow-in, captured on the accepting edge
//   busy    high while digits are being processed
//   done    one-cycle pulse, diff/bout (and ovf) valid
//   diff    (a - b - bin) mod 2^WIDTH, held until the next accepted start
//   bout    borrow-out, 1 iff a < b + bin
//   ovf     only when SUB_SIGNED_OVF_EN is defined: two's-complement
//           overflow of a - b - bin, updated together with bout
//
// Optional feature macro: SUB_SIGNED_OVF_EN

module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int DIGITS = WIDTH / 4;
    localparam int KW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             borrow;
    logic [KW-1:0]    k;

    logic [KW+1:0]    idx;
    logic [3:0]       a_dig;
    logic [3:0]       b_dig;
    logic [4:0]       sub;
    logic             last;
    logic             accept;

    // Digit datapath: 5-bit two's-complement difference, bit 4 is the borrow.
    always_comb begin
        idx    = {k, 2'b00};
        a_dig  = a_r[idx +: 4];
        b_dig  = b_r[idx +: 4];
        sub    = {1'b0, a_dig} - {1'b0, b_dig} - {4'b0000, borrow};
        last   = (k == KW'(DIGITS - 1));
        accept = start && (state != S_BUSY);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_BUSY;
            S_BUSY:  if (last)  state_nx = S_DONE;
            S_DONE:  state_nx = start ? S_BUSY : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign busy = (state == S_BUSY);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            borrow <= 1'b0;
            k      <= '0;
            diff   <= '0;
            bout   <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
            ovf    <= 1'b0;
`endif
        end else if (accept) begin
            a_r    <= a;
            b_r    <= b;
            borrow <= bin;
            k      <= '0;
        end else if (state == S_BUSY) begin
            diff[idx +: 4] <= sub[3:0];
            borrow         <= sub[4];
            // Counter returns to 0 on the final digit instead of wrapping.
            k              <= last ? '0 : k + 1'b1;
            if (last) begin
                bout <= sub[4];
`ifdef SUB_SIGNED_OVF_EN
                // sub[3] is the result MSB being written on this same edge.
                ovf  <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (sub[3] != a_r[WIDTH-1]);
`endif
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
module tb_nibble_serial_subtractor;

    localparam int WIDTH  = 16;
    localparam int DIGITS = WIDTH / 4;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             bin   = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SUB_SIGNED_OVF_EN
    logic             ovf;
`endif

    nibble_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SUB_SIGNED_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             bo;
        logic             ov;
        int               cyc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: plain (WIDTH+1)-bit arithmetic; the extra bit is the borrow.
    function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                   input logic cv, input int when);
        exp_t e;
        logic [WIDTH:0] full;
        full  = {1'b0, av} - {1'b0, bv} - (WIDTH+1)'(cv);
        e.d   = full[WIDTH-1:0];
        e.bo  = full[WIDTH];
        e.ov  = (av[WIDTH-1] != bv[WIDTH-1]) && (full[WIDTH-1] != av[WIDTH-1]);
        e.cyc = when;
        return e;
    endfunction

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        logic [WIDTH-1:0] last_d;
        logic             last_b;
        logic             last_o;
        int               run;
        exp_t             e;
        last_d = '0;
        last_b = 1'b0;
        last_o = 1'b0;
        run    = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                check("reset_busy", 32'(busy), 0);
                check("reset_done", 32'(done), 0);
                check("reset_diff", 32'(diff), 0);
                check("reset_bout", 32'(bout), 0);
`ifdef SUB_SIGNED_OVF_EN
                check("reset_ovf", 32'(ovf), 0);
`endif
                last_d = '0;
                last_b = 1'b0;
                last_o = 1'b0;
                run    = 0;
            end else begin
                check("busy_done_excl", 32'(busy & done), 0);
                if (done) begin
                    check("busy_run_len", 32'(run), 32'(DIGITS));
                    run = 0;
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done=1 expected no pending operation (t=%0t)", $time);
                    end else begin
                        e = sbq.pop_front();
                        check("diff", 32'(diff), 32'(e.d));
                        check("bout", 32'(bout), 32'(e.bo));
`ifdef SUB_SIGNED_OVF_EN
                        check("ovf", 32'(ovf), 32'(e.ov));
`endif
                        check("done_latency", 32'(cyc), 32'(e.cyc));
                        last_d = e.d;
                        last_b = e.bo;
                        last_o = e.ov;
                    end
                end else if (busy) begin
                    run++;
                end else begin
                    run = 0;
                    check("hold_diff", 32'(diff), 32'(last_d));
                    check("hold_bout", 32'(bout), 32'(last_b));
`ifdef SUB_SIGNED_OVF_EN
                    check("hold_ovf", 32'(ovf), 32'(last_o));
`endif
                end
            end
        end
    end

    // All driver tasks start and end on a falling edge.
    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=%b expected 0 within 64 cycles", busy);
        end
    endtask

    task automatic launch(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
        wait_idle();
        a     = av;
        b     = bv;
        bin   = cv;
        start = 1'b1;
        sbq.push_back(model(av, bv, cv, cyc + 1 + DIGITS));
        @(negedge clk);
    endtask

    // Single start pulse; operands scrambled afterwards.
    task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
        launch(av, bv, cv);
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        bin   = 1'($urandom);
    endtask

    // start stays high through the busy phase with changing operands,
    // dropped in the done cycle.
    task automatic issue_hold(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
        int n = 0;
        launch(av, bv, cv);
        while (busy === 1'b1 && n < 64) begin
            a   = WIDTH'($urandom);
            b   = WIDTH'($urandom);
            bin = 1'($urandom);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rc;
        int               mode;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed cases, issued back to back.
        issue(16'h0005, 16'h0003, 1'b0);
        issue(16'hA51B, 16'h52BB, 1'b0);
        issue(16'h0000, 16'h0001, 1'b0);
        issue(16'h1234, 16'h1234, 1'b1);
        issue(16'hFFFF, 16'hFFFF, 1'b0);
        issue(16'hFFFF, 16'h0000, 1'b0);
        issue(16'h8000, 16'h0001, 1'b0);
        issue(16'h0000, 16'h0000, 1'b1);
        repeat (2) @(negedge clk);

        // start held during busy, then an immediate follow-on.
        issue_hold(16'h3C5A, 16'h1F0F, 1'b1);
        issue(16'h7FFF, 16'hFFFF, 1'b0);
        repeat (DIGITS + 3) @(negedge clk);

        // Reset during the second busy cycle: operation is abandoned.
        issue(16'h4321, 16'h1234, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (DIGITS + 4) @(negedge clk);

        // Randomized traffic with boundary-biased operand choices.
        repeat (150) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            ra   = WIDTH'($urandom);
            rb   = WIDTH'($urandom);
            rc   = 1'($urandom);
            mode = $urandom_range(0, 9);
            case (mode)
                0: rb = ra;
                1: begin ra = '1; rb = '0; end
                2: ra = '0;
                3: rb = '1;
                default: ;
            endcase
            if (mode == 4) issue_hold(ra, rb, rc);
            else           issue(ra, rb, rc);
        end

        repeat (DIGITS + 4) @(negedge clk);
        check("queue_drained", 32'(sbq.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
